// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD conversion arbiter.
// Build option: define BCD_BLANK_EN to blank leading zero digits of dout.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // 7-segment blank code substituted for suppressed leading zeros
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Width of a counter that must hold 0 .. w-1
    function automatic int unsigned cnt_width(input int unsigned w);
        int unsigned n;
        n = 1;
        for (int unsigned k = 1; k < 32; k++) begin
            if ((32'd1 << n) < w) n = k + 1;
        end
        return n;
    endfunction

    // True when every w-bit value fits in nd decimal digits
    function automatic bit bcd_fits(input int unsigned w, input int unsigned nd);
        longint unsigned p10;
        p10 = 1;
        for (int unsigned k = 0; k < nd; k++) p10 = p10 * 10;
        return (((64'd1 << w) - 64'd1) < p10);
    endfunction

endpackage

// File: rtl/bcd_dabble.sv
// Iterative shift-add-3 binary-to-BCD core, one bit per clock.
// done/bcd are valid in the cycle whose closing edge performs the final shift.
module bcd_dabble
    import bcd_pkg::*;
#(
    parameter int unsigned W  = 8,
    parameter int unsigned ND = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    bin,
    output logic            done,
    output logic [ND*4-1:0] bcd
);

    localparam int unsigned CW = cnt_width(W);

    logic [W-1:0]    r_bin;
    logic [ND*4-1:0] r_bcd;
    logic [CW-1:0]   r_cnt;
    logic            r_run;

    logic [ND*4-1:0] w_adj;
    logic [ND*4-1:0] w_bcd_nxt;
    logic [W-1:0]    w_bin_nxt;

    // Add 3 to every digit >= 5, then shift {bcd, bin} left by one
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned d = 0; d < ND; d++) begin
            if (r_bcd[d*4 +: 4] >= 4'd5) w_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
        end
        {w_bcd_nxt, w_bin_nxt} = {w_adj, r_bin} << 1;
    end

    assign done = r_run && (r_cnt == CW'(W - 1));
    assign bcd  = w_bcd_nxt;

    // Shift register and bit counter; start reloads and clears the accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_bin <= bin;
            r_bcd <= '0;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_bin <= w_bin_nxt;
            r_bcd <= w_bcd_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (done) r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bcd_dabble among NREQ requesters.
// Build option: define BCD_BLANK_EN to replace leading zero digits with 4'hF.
module bcd_conv_arbiter
    import bcd_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned W    = 8,
    parameter int unsigned ND   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       bin_flat,
    output logic [NREQ-1:0]         ack,
    output logic [ND*4-1:0]         dout,
    output logic [$clog2(NREQ)-1:0] dout_id,
    output logic                    dout_valid,
    output logic                    busy
);

    localparam int unsigned IW = $clog2(NREQ);

    if (!bcd_fits(W, ND)) begin : g_bad_cfg
        $error("bcd_conv_arbiter: 2**W-1 does not fit in ND BCD digits");
    end

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_last;
    logic [IW-1:0]   w_gnt;
    logic            w_found;
    logic            w_start;
    logic            w_done;
    logic [ND*4-1:0] w_bcd;
    logic [ND*4-1:0] w_dout_nxt;
    logic [NREQ-1:0] r_ack;
    logic            r_valid;
    logic [ND*4-1:0] r_dout;
    logic [IW-1:0]   r_id;

`ifdef BCD_BLANK_EN
    // Blank zero digits from the most significant down; digit 0 always shown
    function automatic logic [ND*4-1:0] blank_lead(input logic [ND*4-1:0] v);
        logic lead;
        lead       = 1'b1;
        blank_lead = v;
        for (int unsigned d = ND - 1; d >= 1; d--) begin
            if (lead && (v[d*4 +: 4] == 4'd0)) blank_lead[d*4 +: 4] = BCD_BLANK;
            else lead = 1'b0;
        end
    endfunction
    assign w_dout_nxt = blank_lead(w_bcd);
`else
    assign w_dout_nxt = w_bcd;
`endif

    // Round-robin pick: first requester searching upward from last+1, wrapping
    always_comb begin
        w_gnt   = r_last;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!w_found && req[(32'(r_last) + k) % NREQ]) begin
                w_gnt   = IW'((32'(r_last) + k) % NREQ);
                w_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_nxt = CONV;
            CONV:    if (w_done)  w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        busy    = (r_state != IDLE);
        w_start = (r_state == IDLE) && w_found;
    end

    // Round-robin pointer; also identifies the grant while converting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_last <= IW'(NREQ - 1);
        else if (w_start) r_last <= w_gnt;
    end

    bcd_dabble #(
        .W  (W),
        .ND (ND)
    ) u_dabble (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .bin   (bin_flat[32'(w_gnt)*W +: W]),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // Result registers load on the final shift edge, so they are valid during DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= '0;
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_id    <= '0;
        end else begin
            r_ack   <= '0;
            r_valid <= 1'b0;
            if ((r_state == CONV) && w_done) begin
                r_ack   <= NREQ'(1) << r_last;
                r_valid <= 1'b1;
                r_dout  <= w_dout_nxt;
                r_id    <= r_last;
            end
        end
    end

    assign ack        = r_ack;
    assign dout_valid = r_valid;
    assign dout       = r_dout;
    assign dout_id    = r_id;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed scenarios plus a random phase,
// compared every cycle against a transaction-timing reference model.
// Honours BCD_BLANK_EN the same way as the design.
module tb_bcd_conv_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 8;
    localparam int ND   = 3;
    localparam int IW   = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   bin_flat;
    logic [NREQ-1:0]     ack;
    logic [ND*4-1:0]     dout;
    logic [IW-1:0]       dout_id;
    logic                dout_valid;
    logic                busy;

    bcd_conv_arbiter #(
        .NREQ (NREQ),
        .W    (W),
        .ND   (ND)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .bin_flat   (bin_flat),
        .ack        (ack),
        .dout       (dout),
        .dout_id    (dout_id),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit rnd_mode = 1'b0;
    logic [NREQ-1:0] drop_mask;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decimal digits of v, optionally with leading-zero blanking
    function automatic logic [ND*4-1:0] fmt(input int unsigned v);
        logic [ND*4-1:0] r;
        int unsigned x;
`ifdef BCD_BLANK_EN
        bit lead;
        lead = 1'b1;
`endif
        x = v;
        for (int d = 0; d < ND; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BCD_BLANK_EN
        for (int d = ND - 1; d > 0; d--) begin
            if (lead && r[d*4 +: 4] == 4'd0) r[d*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return r;
    endfunction

    // Next requester in circular order after 'last' that is requesting
    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int off = 1; off <= NREQ; off++)
            if (r[(last + off) % NREQ]) return (last + off) % NREQ;
        return last;
    endfunction

    function automatic logic [W-1:0] op_of(input logic [NREQ*W-1:0] f, input int i);
        return f[i*W +: W];
    endfunction

    // Reference model: a grant starts a W+2 cycle transaction; result shows W edges later
    bit              m_active;
    int              m_age;
    int              m_id;
    int              m_last;
    logic [W-1:0]    m_val;
    logic [NREQ-1:0] m_ack;
    logic [ND*4-1:0] m_dout;
    logic [IW-1:0]   m_dout_id;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  <= 1'b0;
            m_age     <= 0;
            m_id      <= 0;
            m_last    <= NREQ - 1;
            m_val     <= '0;
            m_ack     <= '0;
            m_dout    <= '0;
            m_dout_id <= '0;
        end else begin
            m_ack <= '0;
            if (m_active) begin
                m_age <= m_age + 1;
                if (m_age + 1 == W) begin
                    m_ack     <= NREQ'(1) << m_id;
                    m_dout    <= fmt(int'(m_val));
                    m_dout_id <= IW'(m_id);
                end
                if (m_age + 1 == W + 1) m_active <= 1'b0;
            end else if (|req) begin
                m_id     <= rr_pick(req, m_last);
                m_last   <= rr_pick(req, m_last);
                m_val    <= op_of(bin_flat, rr_pick(req, m_last));
                m_active <= 1'b1;
                m_age    <= 0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Completion log and per-cycle comparison against the model
    int   q_id[$];
    int   q_dout[$];
    int   q_cyc[$];
    int   q_ack[$];
    int   q_gnt[$];
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack",        32'(ack),        32'(m_ack));
            chk("dout_valid", 32'(dout_valid), 32'(|m_ack));
            chk("dout",       32'(dout),       32'(m_dout));
            chk("dout_id",    32'(dout_id),    32'(m_dout_id));
            chk("busy",       32'(busy),       32'(m_active));
        end
        if (dout_valid) begin
            q_id.push_back(int'(dout_id));
            q_dout.push_back(int'(dout));
            q_cyc.push_back(cyc);
            q_ack.push_back(int'(ack));
        end
        if (busy && !prev_busy) q_gnt.push_back(cyc);
        prev_busy <= busy;
    end

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] v;
        v = W'($urandom);
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            default: ;
        endcase
        return v;
    endfunction

    // One clock step; inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
        if (rnd_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    bin_flat[i*W +: W] = rand_op();
                    req[i] = 1'b1;
                end else if ($urandom_range(0, 7) == 0) begin
                    bin_flat[i*W +: W] = rand_op();
                end
            end
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (ack[i] && drop_mask[i]) req[i] = 1'b0;
        end
    endtask

    task automatic wait_ev(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (q_id.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(q_id.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        req = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic single(input int id, input int v, input string tag);
        int b;
        req = '0;
        repeat (3) tick();
        b = q_id.size();
        bin_flat[id*W +: W] = W'(v);
        req[id] = 1'b1;
        wait_ev(b + 1, 30, {tag, "_timeout"});
        if (q_id.size() > b) begin
            chk({tag, "_dout"}, 32'(q_dout[b]), 32'(fmt(v)));
            chk({tag, "_id"},   32'(q_id[b]),   32'(id));
        end
    endtask

    int b, gb, pos;

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        bin_flat  = '0;
        drop_mask = '1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_ack",   32'(ack),        32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_dout",  32'(dout),       32'd0);
        chk("rst_id",    32'(dout_id),    32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        tick();

        // Single request on requester 1
        b  = q_id.size();
        gb = q_gnt.size();
        bin_flat[1*W +: W] = W'(173);
        req = 3'b010;
        wait_ev(b + 1, 30, "t1_timeout");
        if (q_id.size() > b && q_gnt.size() > gb) begin
            chk("t1_dout", 32'(q_dout[b]), 32'(fmt(173)));
            chk("t1_id",   32'(q_id[b]),   32'd1);
            chk("t1_ack",  32'(q_ack[b]),  32'b010);
            chk("t1_lat",  32'(q_cyc[b] - q_gnt[gb]), 32'(W));
        end

        // Three simultaneous requests from a fresh pointer
        do_reset();
        b = q_id.size();
        bin_flat = {W'(255), W'(99), W'(5)};
        req = 3'b111;
        wait_ev(b + 3, 60, "t2_timeout");
        if (q_id.size() > b + 2) begin
            for (int i = 0; i < 3; i++) begin
                chk("t2_id",   32'(q_id[b+i]),   32'(i));
                chk("t2_dout", 32'(q_dout[b+i]), 32'(fmt(int'(op_of(bin_flat, i)))));
            end
            chk("t2_gap01", 32'(q_cyc[b+1] - q_cyc[b]),   32'(W + 2));
            chk("t2_gap12", 32'(q_cyc[b+2] - q_cyc[b+1]), 32'(W + 2));
        end

        // Fairness: 0 and 2 held continuously, then 1 joins
        do_reset();
        drop_mask = 3'b010;
        b = q_id.size();
        bin_flat = {W'(42), W'(17), W'(128)};
        req = 3'b101;
        wait_ev(b + 4, 80, "t3_timeout");
        if (q_id.size() > b + 3) begin
            chk("t3_id0", 32'(q_id[b]),   32'd0);
            chk("t3_id1", 32'(q_id[b+1]), 32'd2);
            chk("t3_id2", 32'(q_id[b+2]), 32'd0);
            chk("t3_id3", 32'(q_id[b+3]), 32'd2);
        end
        b = q_id.size();
        req[1] = 1'b1;
        wait_ev(b + 3, 60, "t3b_timeout");
        pos = -1;
        for (int i = b; i < q_id.size() && i < b + 3; i++)
            if (pos < 0 && q_id[i] == 1) pos = i - b;
        chk("t3_req1_served", 32'(pos >= 0 && pos <= NREQ - 1), 32'd1);
        req = '0;
        drop_mask = '1;
        repeat (W + 4) tick();

        // Extremes
        single(0, 0,   "t4_zero");
        single(0, 255, "t4_max");
        single(0, 10,  "t4_ten");
        single(2, 7,   "t4_seven");

        // Reset mid-conversion with request held
        req = '0;
        repeat (3) tick();
        bin_flat[0 +: W] = W'(123);
        req = 3'b001;
        for (int k = 0; k < 5 && !busy; k++) tick();
        repeat (4) tick();
        b = q_id.size();
        rst_n = 1'b0;
        #1;
        chk("t5_busy",  32'(busy),       32'd0);
        chk("t5_ack",   32'(ack),        32'd0);
        chk("t5_valid", 32'(dout_valid), 32'd0);
        chk("t5_dout",  32'(dout),       32'd0);
        tick();
        rst_n = 1'b1;
        chk("t5_noack", 32'(q_id.size()), 32'(b));
        wait_ev(b + 1, 20, "t5_timeout");
        if (q_id.size() > b) chk("t5_result", 32'(q_dout[b]), 32'(fmt(123)));

        // Operand change after the grant edge is ignored
        req = '0;
        repeat (3) tick();
        b = q_id.size();
        bin_flat[0 +: W] = W'(200);
        req = 3'b001;
        tick();
        bin_flat[0 +: W] = W'(7);
        wait_ev(b + 1, 20, "t6_timeout");
        if (q_id.size() > b) chk("t6_dout", 32'(q_dout[b]), 32'(fmt(200)));

        // Random traffic against the model
        req = '0;
        repeat (3) tick();
        rnd_mode = 1'b1;
        repeat (600) tick();
        rnd_mode = 1'b0;
        rst_n = 1'b1;
        req = '0;
        repeat (W + 6) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
